// File: rtl/lfsr_gen.sv
// Parameterised Galois/Fibonacci LFSR with ready/valid output, seed reload,
// all-zero lockup recovery and period measurement.
module lfsr_gen #(
  parameter int unsigned      LEN   = 8,
  parameter logic [LEN-1:0]   TAPS  = LEN'(8'b10111000),
  parameter int unsigned      MODE  = 0,
  parameter int unsigned      STEPS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LEN-1:0]     seed,
  input  logic               seed_load,
  input  logic               out_ready,
  output logic [LEN-1:0]     value,
  output logic [STEPS-1:0]   out_bits,
  output logic               out_valid,
  output logic               lockup,
  output logic               period_done,
  output logic [LEN-1:0]     period
);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [LEN-1:0]   value_q, value_d;
  logic [LEN-1:0]   start_q, start_d;
  logic [LEN-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic             pd_q, pd_d;

  logic [LEN-1:0]   eff_seed;
  logic [LEN-1:0]   adv_c;
  logic [STEPS-1:0] bits_c;

  function automatic logic [LEN-1:0] step1(input logic [LEN-1:0] v);
    if (MODE == 0) begin
      return {1'b0, v[LEN-1:1]} ^ (v[0] ? TAPS : '0);
    end else begin
      return {^(v & TAPS), v[LEN-1:1]};
    end
  endfunction

  assign eff_seed = (seed == '0) ? '1 : seed;

  // Unrolled STEPS-deep chain; each stage's LSB is the bit it shifts out.
  always_comb begin
    logic [LEN-1:0] v;
    v      = value_q;
    bits_c = '0;
    for (int i = 0; i < STEPS; i++) begin
      bits_c[i] = v[0];
      v         = step1(v);
    end
    adv_c = v;
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lockup_d = 1'b0;
    pd_d     = 1'b0;

    if (seed_load) begin
      value_d = eff_seed;
      start_d = eff_seed;
      cnt_d   = '0;
      state_d = ST_LOAD;
    end else if (state_q == ST_LOAD) begin
      state_d = ST_RUN;
    end else if (value_q == '0) begin
      // Stuck state: recover to all ones and restart the period measurement.
      value_d  = '1;
      start_d  = '1;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else if (out_ready) begin
      value_d = adv_c;
      if (adv_c == start_q) begin
        pd_d     = 1'b1;
        period_d = cnt_q + LEN'(1);
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + LEN'(1);
      end
    end

    valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      value_q  <= eff_seed;
      start_q  <= eff_seed;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      pd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      pd_q     <= pd_d;
    end
  end

  assign value       = value_q;
  assign out_bits    = bits_c;
  assign out_valid   = valid_q;
  assign lockup      = lockup_q;
  assign period_done = pd_q;
  assign period      = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Galois/Fibonacci stepping, multi-step advance,
// backpressure, reload, lockup recovery, period detection and reset.
module tb_lfsr_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] seed_g, seed_x, seed_z;
  logic       ld_g, rdy_g, ld_x, rdy_x;

  logic [7:0] val_g, per_g;
  logic       bits_g, vld_g, lk_g, pd_g;
  logic [7:0] val_f, per_f;
  logic       bits_f, vld_f, lk_f, pd_f;
  logic [7:0] val_s, per_s, bits_s;
  logic       vld_s, lk_s, pd_s;
  logic [7:0] val_z, per_z;
  logic       bits_z, vld_z, lk_z, pd_z;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_gen u_g (
    .clock(clock), .reset(reset), .seed(seed_g), .seed_load(ld_g), .out_ready(rdy_g),
    .value(val_g), .out_bits(bits_g), .out_valid(vld_g), .lockup(lk_g),
    .period_done(pd_g), .period(per_g));

  lfsr_gen #(.MODE(1)) u_f (
    .clock(clock), .reset(reset), .seed(seed_x), .seed_load(ld_x), .out_ready(rdy_x),
    .value(val_f), .out_bits(bits_f), .out_valid(vld_f), .lockup(lk_f),
    .period_done(pd_f), .period(per_f));

  lfsr_gen #(.STEPS(8)) u_s (
    .clock(clock), .reset(reset), .seed(seed_x), .seed_load(ld_x), .out_ready(rdy_x),
    .value(val_s), .out_bits(bits_s), .out_valid(vld_s), .lockup(lk_s),
    .period_done(pd_s), .period(per_s));

  lfsr_gen #(.TAPS(8'h00)) u_z (
    .clock(clock), .reset(reset), .seed(seed_z), .seed_load(ld_x), .out_ready(rdy_x),
    .value(val_z), .out_bits(bits_z), .out_valid(vld_z), .lockup(lk_z),
    .period_done(pd_z), .period(per_z));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] gstep(input logic [7:0] v);
    logic [7:0] t;
    t = v >> 1;
    if (v[0]) t = t ^ 8'hB8;
    return t;
  endfunction

  // Reference for the 8-step advance: next model state and the bits it shifts out.
  logic [7:0] m_val, m_bits;
  task automatic model_advance8();
    for (int i = 0; i < 8; i++) begin
      m_bits[i] = m_val[0];
      m_val     = gstep(m_val);
    end
  endtask

  task automatic run_period(input logic [7:0] s, input logic [7:0] exp_start);
    int pulses;
    int first;
    seed_g = s; ld_g = 1'b1; rdy_g = 1'b1;
    tick();
    chk("pload_vld", 64'(vld_g), 64'(1'b0));
    chk("pload_val", 64'(val_g), 64'(exp_start));
    ld_g = 1'b0;
    tick();
    chk("prun_vld", 64'(vld_g), 64'(1'b1));
    chk("prun_val", 64'(val_g), 64'(exp_start));
    pulses = 0;
    first  = 0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (pd_g) begin
        pulses++;
        if (first == 0) begin
          first = n;
          chk("pd_period", 64'(per_g), 64'(8'd255));
          chk("pd_value", 64'(val_g), 64'(exp_start));
        end
      end
    end
    chk("pd_first", 64'(first), 64'(255));
    chk("pd_pulses", 64'(pulses), 64'(1));
  endtask

  initial begin
    reset = 1'b1;
    seed_g = 8'h00; seed_x = 8'h00; seed_z = 8'h01;
    ld_g = 1'b0; ld_x = 1'b0; rdy_g = 1'b1; rdy_x = 1'b1;

    // Reset edge
    tick();
    reset = 1'b0;
    chk("rst_val_g", 64'(val_g), 64'(8'hFF));
    chk("rst_vld_g", 64'(vld_g), 64'(1'b0));
    chk("rst_per_g", 64'(per_g), 64'(8'h00));
    chk("rst_lk_g", 64'(lk_g), 64'(1'b0));
    chk("rst_pd_g", 64'(pd_g), 64'(1'b0));
    chk("rst_val_z", 64'(val_z), 64'(8'h01));

    // LOAD -> RUN
    tick();
    chk("run_vld_g", 64'(vld_g), 64'(1'b1));
    chk("run_val_g", 64'(val_g), 64'(8'hFF));
    chk("run_bits_g", 64'(bits_g), 64'(1'b1));
    chk("run_val_f", 64'(val_f), 64'(8'hFF));
    chk("run_val_s", 64'(val_s), 64'(8'hFF));
    m_val = 8'hFF;
    model_advance8();
    chk("s8_bits0", 64'(bits_s), 64'(m_bits));

    tick();
    chk("adv1_g", 64'(val_g), 64'(8'hC7));
    chk("adv1_bits_g", 64'(bits_g), 64'(1'b1));
    chk("adv1_f", 64'(val_f), 64'(8'h7F));
    chk("s8_val1", 64'(val_s), 64'(m_val));
    model_advance8();
    chk("s8_bits1", 64'(bits_s), 64'(m_bits));
    chk("z_zero", 64'(val_z), 64'(8'h00));
    chk("z_lk_pre", 64'(lk_z), 64'(1'b0));

    tick();
    chk("adv2_g", 64'(val_g), 64'(8'hDB));
    chk("adv2_bits_g", 64'(bits_g), 64'(1'b1));
    chk("adv2_f", 64'(val_f), 64'(8'hBF));
    chk("s8_val2", 64'(val_s), 64'(m_val));
    model_advance8();
    chk("s8_bits2", 64'(bits_s), 64'(m_bits));
    chk("z_recover", 64'(val_z), 64'(8'hFF));
    chk("z_lk_pulse", 64'(lk_z), 64'(1'b1));

    tick();
    chk("adv3_g", 64'(val_g), 64'(8'hD5));
    chk("s8_val3", 64'(val_s), 64'(m_val));
    chk("z_lk_end", 64'(lk_z), 64'(1'b0));
    chk("z_next", 64'(val_z), 64'(8'h7F));

    // Backpressure: ready 1,0,0,1 after reload to all ones
    seed_g = 8'h00; ld_g = 1'b1; rdy_g = 1'b1;
    tick();
    chk("bp_load_vld", 64'(vld_g), 64'(1'b0));
    ld_g = 1'b0;
    tick();
    chk("bp_val0", 64'(val_g), 64'(8'hFF));
    rdy_g = 1'b1; tick(); chk("bp_val1", 64'(val_g), 64'(8'hC7));
    rdy_g = 1'b0; tick(); chk("bp_val2", 64'(val_g), 64'(8'hC7));
    chk("bp_bits2", 64'(bits_g), 64'(1'b1));
    rdy_g = 1'b0; tick(); chk("bp_val3", 64'(val_g), 64'(8'hC7));
    rdy_g = 1'b1; tick(); chk("bp_val4", 64'(val_g), 64'(8'hDB));

    // Load coincident with ready, then full period from 5A and from all ones
    run_period(8'h5A, 8'h5A);
    run_period(8'h00, 8'hFF);

    // Reset mid-run overrides load/ready and discards the period
    reset = 1'b1; ld_g = 1'b1; rdy_g = 1'b1; seed_g = 8'h3C;
    tick();
    reset = 1'b0; ld_g = 1'b0;
    chk("mrst_val", 64'(val_g), 64'(8'h3C));
    chk("mrst_vld", 64'(vld_g), 64'(1'b0));
    chk("mrst_per", 64'(per_g), 64'(8'h00));
    tick();
    chk("mrst_vld2", 64'(vld_g), 64'(1'b1));
    chk("mrst_val2", 64'(val_g), 64'(8'h3C));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter LEN, default 8, shift register length, legal 2..64.
REQ-002 Parameter TAPS, default 8'b10111000, LEN-bit XOR tap mask.
REQ-003 Parameter MODE, default 0, 0 = Galois, 1 = Fibonacci.
REQ-004 Parameter STEPS, default 1, LFSR steps per advance, legal 1..LEN.
REQ-005 Port list, one per line: name, direction, width, meaning:
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- seed  input  LEN  seed value; zero selects default seed of all ones.
- seed_load  input  1  reload request; one-cycle pulse or level.
- out_ready  input  1  consumer accepts current value.
- value  output  LEN  current LFSR state.
- out_bits  output  STEPS  bits shifted out by the pending advance.
- out_valid  output  1  value/out_bits valid.
- lockup  output  1  one-cycle pulse on all-zero recovery.
- period_done  output  1  one-cycle pulse when state returns to start value.
- period  output  LEN  advance count of last completed period.

Function
REQ-006 Galois single step SHALL be next = {0, v[LEN-1:1]} XOR (v[0] ? TAPS : 0).
REQ-007 Fibonacci single step SHALL be next = {fb, v[LEN-1:1]}, fb = XOR-reduce(v AND TAPS).
REQ-008 One advance SHALL apply STEPS single steps combinationally within one cycle.
REQ-009 out_bits[i] SHALL equal bit 0 of the state before single step i of the pending advance (i = 0 first); combinational from value.
REQ-010 Effective seed SHALL be seed when nonzero, else all ones.
REQ-011 State LOAD: out_valid = 0; next cycle SHALL enter RUN unconditionally.
REQ-012 State RUN: out_valid = 1; advance occurs in a cycle where out_valid AND out_ready, value updating at that edge.
REQ-013 out_ready low in RUN SHALL hold value, out_bits and step count unchanged.
REQ-014 seed_load high SHALL load effective seed into value and start register, clear step count, enter LOAD; applies in either state.
REQ-015 seed_load and out_ready in the same cycle: load SHALL win, no advance.
REQ-016 Step counter (LEN bits) SHALL increment by 1 per advance, wrapping modulo 2^LEN.
REQ-017 When an advance produces a state equal to the start register, period_done SHALL pulse the following cycle, period SHALL latch counter+1, and the counter SHALL clear.
REQ-018 With STEPS > 1, period detection SHALL compare only post-advance states; intermediate single-step states are ignored.
REQ-019 In RUN, value equal to zero SHALL be replaced by all ones at the next edge instead of advancing, pulsing lockup the following cycle, start register set to all ones, counter cleared.
REQ-020 lockup and period_done SHALL be registered outputs, high for exactly one cycle per event.
REQ-021 Latency from seed_load to first out_valid SHALL be 2 edges (load edge, LOAD-to-RUN edge).

Reset
REQ-022 While reset is high, value and start register SHALL take effective seed, state SHALL be LOAD, counter and period SHALL be 0, lockup and period_done 0.
REQ-023 reset SHALL override seed_load and out_ready; reset mid-run discards the current period.
REQ-024 First cycle after reset deasserts out_valid SHALL be 0; second cycle SHALL be 1.

Verification
REQ-025 Defaults, seed=0, reset 1 cycle, out_ready=1 -> value FF, out_valid 0 then 1, then value C7, DB, D5 on successive cycles, out_bits 1 each.
REQ-026 MODE=1, seed=0, out_ready=1 -> value FF, 7F, BF.
REQ-027 Defaults, out_ready toggled 1,0,0,1 -> value C7, C7, C7, DB; no skipped or repeated advances.
REQ-028 Defaults, out_ready held 1 for 255 advances -> period_done single pulse, period=255, value FF again.
REQ-029 seed_load with seed=0x5A coincident with out_ready -> value 5A, out_valid 0 one cycle, first accepted value 5A, counter 0.
REQ-030 STEPS=8 vs STEPS=1 from same seed -> each STEPS=8 value equals every 8th STEPS=1 value; out_bits matches the 8 shifted-out bits LSB first.
